// File: rtl/photonic_layer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : photonic_layer_pipe
//  Description : Multi-channel pipelined photonic layer stage. CHANNELS lanes
//                of PRECISION-bit samples per beat, transformed per lane at
//                stage-0 capture (BYPASS / WRAP / SAT / RELU), then carried
//                through LATENCY register stages under valid/ready with full
//                backpressure. Counts accepted beats with any lane overflow.
//  Ports       : clk, rst_n (async active-low)
//                data_in/mode_in/valid_in/ready_out  - upstream beat
//                data_out/valid_out/ready_in         - downstream beat
//                busy            - any stage holds a valid beat
//                overflow_count  - saturating count of overflowed beats
//  Revision    : 1.0 - initial release
// ============================================================================
module photonic_layer_pipe #(
    parameter int PRECISION = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2,
    parameter int OFFSET    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*PRECISION-1:0] data_in,
    input  logic [1:0]                    mode_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [CHANNELS*PRECISION-1:0] data_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          busy,
    output logic [15:0]                   overflow_count
);

    localparam int                 c_W           = CHANNELS * PRECISION;
    localparam logic [1:0]         c_MODE_BYPASS = 2'd0;
    localparam logic [1:0]         c_MODE_WRAP   = 2'd1;
    localparam logic [1:0]         c_MODE_SAT    = 2'd2;
    localparam logic [1:0]         c_MODE_RELU   = 2'd3;
    localparam logic [PRECISION:0] c_OFFSET      = (PRECISION + 1)'(OFFSET);
    localparam logic [15:0]        c_CNT_MAX     = 16'hFFFF;

    logic [c_W-1:0]      r_d [LATENCY];
    logic [LATENCY-1:0]  r_v;
    logic [LATENCY-1:0]  w_adv;
    logic [c_W-1:0]      w_xf;
    logic [CHANNELS-1:0] w_lane_ovf;
    logic                w_accept;
    logic [15:0]         r_ovf_cnt;

    // Per-lane transform; the sum carries one extra bit so its MSB is the carry-out.
    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_lane
            logic [PRECISION-1:0] w_in;
            logic [PRECISION:0]   w_sum;
            logic [PRECISION-1:0] w_out;
            logic                 w_ovf;

            assign w_in  = data_in[c*PRECISION +: PRECISION];
            assign w_sum = {1'b0, w_in} + c_OFFSET;

            always_comb begin
                w_out = w_in;
                w_ovf = 1'b0;
                case (mode_in)
                    c_MODE_BYPASS: w_out = w_in;
                    c_MODE_WRAP: begin
                        w_out = w_sum[PRECISION-1:0];
                        w_ovf = w_sum[PRECISION];
                    end
                    c_MODE_SAT: begin
                        w_out = w_sum[PRECISION] ? {PRECISION{1'b1}} : w_sum[PRECISION-1:0];
                        w_ovf = w_sum[PRECISION];
                    end
                    c_MODE_RELU: w_out = w_in[PRECISION-1] ? '0 : w_in;
                    default: w_out = w_in;
                endcase
            end

            assign w_xf[c*PRECISION +: PRECISION] = w_out;
            assign w_lane_ovf[c]                  = w_ovf;
        end
    endgenerate

    // Advance chain runs from the output back to the input, so an empty stage
    // anywhere lets everything upstream of it move (no bubble).
    always_comb begin
        w_adv[LATENCY-1] = !r_v[LATENCY-1] || ready_in;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            w_adv[k] = !r_v[k] || w_adv[k+1];
        end
    end

    assign ready_out = w_adv[0];
    assign w_accept  = valid_in && ready_out;

    // Data registers load only alongside a valid beat, so unqualified input
    // data never reaches a stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_v[k] <= 1'b0;
                r_d[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= valid_in;
                if (valid_in) begin
                    r_d[0] <= w_xf;
                end
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
        end
    end

    // One increment per overflowed beat regardless of lane count; sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_accept && (|w_lane_ovf) && (r_ovf_cnt != c_CNT_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign valid_out      = r_v[LATENCY-1];
    assign data_out       = r_d[LATENCY-1];
    assign busy           = |r_v;
    assign overflow_count = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_photonic_layer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_photonic_layer_pipe
//  Description : Self-checking bench for photonic_layer_pipe. Directed beats
//                with hand-computed results, backpressure and mid-stream
//                reset, then randomized valid/ready traffic scored against a
//                queue-based arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_photonic_layer_pipe;

    localparam int c_P   = 8;
    localparam int c_CH  = 4;
    localparam int c_L   = 2;
    localparam int c_OFF = 1;
    localparam int c_MAX = (1 << c_P) - 1;
    localparam int c_W   = c_P * c_CH;

    logic             clk;
    logic             rst_n;
    logic [c_W-1:0]   data_in;
    logic [1:0]       mode_in;
    logic             valid_in;
    logic             ready_out;
    logic [c_W-1:0]   data_out;
    logic             valid_out;
    logic             ready_in;
    logic             busy;
    logic [15:0]      overflow_count;

    photonic_layer_pipe #(
        .PRECISION (c_P),
        .CHANNELS  (c_CH),
        .LATENCY   (c_L),
        .OFFSET    (c_OFF)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .mode_in        (mode_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .busy           (busy),
        .overflow_count (overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [c_W-1:0] exp_q[$];
    int             ovf_model = 0;
    bit             acc;
    bit             emt;
    bit             stall_prev = 0;
    logic [c_W-1:0] held_d;
    int             n_out = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference transform: plain integer arithmetic on each lane.
    function automatic void model(input logic [c_W-1:0] d, input logic [1:0] m,
                                  output logic [c_W-1:0] o, output bit ov);
        o  = '0;
        ov = 0;
        for (int c = 0; c < c_CH; c++) begin
            int x;
            int s;
            int y;
            x = int'((d >> (c * c_P)) & c_W'(c_MAX));
            s = x + c_OFF;
            case (m)
                2'd0: y = x;
                2'd1: begin y = s % (c_MAX + 1); if (s > c_MAX) ov = 1; end
                2'd2: begin y = (s > c_MAX) ? c_MAX : s; if (s > c_MAX) ov = 1; end
                default: y = (x >= (c_MAX + 1) / 2) ? 0 : x;
            endcase
            o = o | (c_W'(y) << (c * c_P));
        end
    endfunction

    // One clock: observe the handshake at the falling edge, update the model,
    // then step past the rising edge.
    task automatic cycle();
        logic [c_W-1:0] e;
        bit             ov;
        @(negedge clk);
        acc = 0;
        emt = 0;
        if (rst_n) begin
            acc = valid_in && ready_out;
            emt = valid_out && ready_in;
            check("busy", busy, exp_q.size() != 0);
            check("ovf_count", overflow_count, ovf_model);
            if (stall_prev) begin
                check("hold_valid", valid_out, 1);
                check("hold_data", data_out, held_d);
            end
            if (emt) begin
                if (exp_q.size() == 0) check("spurious_beat", 1, 0);
                else check("data_out", data_out, exp_q.pop_front());
                n_out++;
            end
            if (acc) begin
                model(data_in, mode_in, e, ov);
                exp_q.push_back(e);
                if (ov && ovf_model < 65535) ovf_model++;
            end
            stall_prev = valid_out && !ready_in;
            held_d     = data_out;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [c_W-1:0] d, input logic [1:0] m);
        bit done;
        done     = 0;
        data_in  = d;
        mode_in  = m;
        valid_in = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = acc;
        end
        if (!done) check("send_timeout", 0, 1);
        valid_in = 1'b0;
        data_in  = $urandom;
    endtask

    // Single beat into an empty pipe with ready_in=1: checks latency and result.
    task automatic directed(input string tag, input logic [c_W-1:0] d, input logic [1:0] m,
                            input logic [c_W-1:0] exp_d, input int exp_cnt);
        send(d, m);
        check({tag, "_lat0"}, valid_out, 0);
        cycle();
        check({tag, "_lat1"}, valid_out, 1);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_count"}, overflow_count, exp_cnt);
        cycle();
    endtask

    initial begin
        int             b;
        int             start;
        int             cyc;
        int             n_rand;
        logic [c_W-1:0] beats [6];
        logic [c_W-1:0] rd;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in  = '0;
        mode_in  = 2'd0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_count", overflow_count, 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", ready_out, 1);
        cycle();

        // Directed transforms
        directed("wrap", 32'hFF7F0010, 2'd1, 32'h00800111, 1);
        directed("sat",  32'hFF7F0010, 2'd2, 32'hFF800111, 2);
        directed("byp",  32'hFFFFFFFF, 2'd0, 32'hFFFFFFFF, 2);
        directed("relu", 32'h80FF017F, 2'd3, 32'h0000017F, 2);

        // Backpressure: only LATENCY beats fit, output held stable
        for (int i = 0; i < 6; i++) beats[i] = 32'h11111111 * (i + 1);
        ready_in = 1'b0;
        b = 0;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            data_in  = beats[b];
            mode_in  = 2'd0;
            cycle();
            if (acc) b++;
        end
        check("bp_accepted", b, c_L);
        check("bp_ready", ready_out, 0);
        check("bp_valid", valid_out, 1);
        check("bp_head", data_out, beats[0]);
        ready_in = 1'b1;
        start = n_out;
        cyc = 0;
        while ((n_out - start) < 6 && cyc < 30) begin
            if (b < 6) begin
                valid_in = 1'b1;
                data_in  = beats[b];
            end else begin
                valid_in = 1'b0;
            end
            cycle();
            cyc++;
            if (acc) b++;
        end
        valid_in = 1'b0;
        check("bp_drained", n_out - start, 6);
        check("bp_cycles", cyc, 6);

        // Reset mid-stream with two beats in flight
        ready_in = 1'b0;
        send(32'hDEADBEEF, 2'd0);
        send(32'h01020304, 2'd1);
        check("mid_full", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_valid", valid_out, 0);
        check("mid_busy", busy, 0);
        check("mid_data", data_out, 0);
        check("mid_count", overflow_count, 0);
        exp_q.delete();
        ovf_model  = 0;
        stall_prev = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ready_in = 1'b1;
        repeat (5) cycle();
        check("mid_no_stale", valid_out, 0);

        // Randomized traffic against the scoreboard
        n_rand = 0;
        cyc = 0;
        while (n_rand < 10000 && cyc < 60000) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) rd[7:0] = 8'hFF;
            if ($urandom_range(0, 7) == 0) rd[31:24] = 8'hFF;
            data_in = rd;
            mode_in = 2'($urandom_range(0, 3));
            cycle();
            cyc++;
            if (acc) n_rand++;
        end
        check("rand_beats", n_rand, 10000);
        valid_in = 1'b0;
        ready_in = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            cycle();
            cyc++;
        end
        cycle();
        check("rand_empty", exp_q.size(), 0);
        check("rand_busy", busy, 0);
        check("rand_count", overflow_count, ovf_model);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
